up_wishbone_master: RTL and testbench
=====================================

// Module: up_wishbone_master
// PURPOSE
//  Bridge from the uP register request interface to a Wishbone classic master.
//  Serves as the initiator counterpart of up_wishbone_classic: a uP-side
//  core issues up_wreq/up_rreq, and this block runs one single-beat Wishbone
//  classic cycle per request, then returns up_wack/up_rack (with up_rdata).
//  Sits between a local controller and a Wishbone interconnect or slave.
// PARAMETERS
//  ADDRESS_WIDTH   16   Wishbone byte-address width
//  BUS_WIDTH       4    data bus width in bytes (power of 2); data = BUS_WIDTH*8 bits
//  TIMEOUT_CYCLES  255  max wait for ack/err per cycle; 0 disables the timeout
// PORTS
//  clk          in   1                   system clock, all logic on rising edge
//  rstn         in   1                   asynchronous active-low reset
//  up_rreq      in   1                   read request, held until up_rack
//  up_rack      out  1                   read acknowledge, 1-cycle pulse
//  up_raddr     in   AW-log2(BUS_WIDTH)  read word address
//  up_rdata     out  BUS_WIDTH*8         read data, valid with up_rack
//  up_wreq      in   1                   write request, held until up_wack
//  up_wack      out  1                   write acknowledge, 1-cycle pulse
//  up_waddr     in   AW-log2(BUS_WIDTH)  write word address
//  up_wdata     in   BUS_WIDTH*8         write data
//  m_wb_cyc     out  1                   Wishbone cycle
//  m_wb_stb     out  1                   Wishbone strobe
//  m_wb_we      out  1                   Wishbone write enable
//  m_wb_addr    out  ADDRESS_WIDTH       byte address = {up_addr, log2(BUS_WIDTH) zeros}
//  m_wb_data_o  out  BUS_WIDTH*8         write data
//  m_wb_sel     out  BUS_WIDTH           byte selects
//  m_wb_cti     out  3                   constant 3'b000 (classic)
//  m_wb_bte     out  2                   constant 2'b00
//  m_wb_ack     in   1                   slave acknowledge
//  m_wb_err     in   1                   slave error
//  m_wb_data_i  in   BUS_WIDTH*8         read data from slave
//  wb_error     out  1                   1-cycle pulse: cycle ended by err or timeout
// BEHAVIOUR
//  - Reset (rstn low, async): all outputs 0, state IDLE, timeout count 0.
//    Mid-cycle reset drops cyc/stb immediately; no ack is issued for it.
//  - FSM IDLE -> BUS -> RESP -> IDLE.
//  - IDLE: if up_wreq, latch waddr/wdata, we=1; else if up_rreq, latch raddr,
//    we=0. Write wins when both asserted; the read is served next.
//    Next edge: cyc=stb=1, sel=all ones, state BUS.
//  - BUS: address/data/we/sel stable. Hold until m_wb_ack or m_wb_err sampled
//    high, or count reaches TIMEOUT_CYCLES. At that edge: cyc=stb=sel=0,
//    data_o=0, state RESP. Read ack latches m_wb_data_i into up_rdata.
//    err/timeout: up_rdata=0, wb_error=1 for one cycle. ack+err same cycle = err.
//  - Timeout count clears on entering BUS, +1 each BUS cycle with no ack/err.
//  - RESP: up_wack (write) or up_rack (read) high exactly one cycle, then IDLE.
//    Requester drops req on the edge where it samples ack, so IDLE never
//    re-issues a completed request.
//  - up_rdata holds its value until the next read completes.
//  - Latency: req high at edge N -> cyc/stb high after N; slave ack sampled at
//    edge M -> up_*ack high in cycle after M. Minimum req-to-ack: 3 cycles.
//  - One transaction outstanding; req changes while not IDLE are ignored.
// TESTING
//  1 Write: up_waddr=0x3, up_wdata=0xAAAA0001, slave acks 1st BUS cycle ->
//    m_wb_addr=0x000C, we=1, sel=4'hF, data_o=0xAAAA0001; up_wack 1 pulse.
//  2 Read: up_raddr=0x2, slave returns 0xFEEDBABE after 3 wait cycles ->
//    cyc/stb high 4 cycles, up_rdata=0xFEEDBABE with up_rack pulse.
//  3 Simultaneous wreq+rreq -> write cycle completes and acks first, then a
//    read cycle; exactly one up_wack and one up_rack.
//  4 Read with no slave response, TIMEOUT_CYCLES=8 -> cyc drops after 8 BUS
//    cycles, up_rack with up_rdata=0, wb_error pulse.
//  5 m_wb_err on write -> cycle ends, up_wack and wb_error both pulse once.
//  6 rstn low mid-BUS -> cyc/stb/acks 0 without a clock; after release, new
//    read completes normally.

Source files
------------

// File: rtl/up_wishbone_master.sv
// uP register request interface to Wishbone classic master bridge.
// Runs one single-beat Wishbone cycle per up_wreq/up_rreq and answers with a one-cycle ack.
module up_wishbone_master #(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned BUS_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned AddrLsb       = $clog2(BUS_WIDTH),
  localparam int unsigned WordAw        = ADDRESS_WIDTH - AddrLsb,
  localparam int unsigned DataW         = BUS_WIDTH * 8,
  localparam int unsigned CntW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     up_rreq,
  output logic                     up_rack,
  input  logic [WordAw-1:0]        up_raddr,
  output logic [DataW-1:0]         up_rdata,
  input  logic                     up_wreq,
  output logic                     up_wack,
  input  logic [WordAw-1:0]        up_waddr,
  input  logic [DataW-1:0]         up_wdata,
  output logic                     m_wb_cyc,
  output logic                     m_wb_stb,
  output logic                     m_wb_we,
  output logic [ADDRESS_WIDTH-1:0] m_wb_addr,
  output logic [DataW-1:0]         m_wb_data_o,
  output logic [BUS_WIDTH-1:0]     m_wb_sel,
  output logic [2:0]               m_wb_cti,
  output logic [1:0]               m_wb_bte,
  input  logic                     m_wb_ack,
  input  logic                     m_wb_err,
  input  logic [DataW-1:0]         m_wb_data_i,
  output logic                     wb_error
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [WordAw-1:0]      addr_q, addr_d;
  logic [DataW-1:0]       wdata_q, wdata_d;
  logic                   cyc_q, cyc_d;
  logic [BUS_WIDTH-1:0]   sel_q, sel_d;
  logic [DataW-1:0]       rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   timeout;

  // A zero TIMEOUT_CYCLES waits forever for the slave.
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cyc_d   = cyc_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (up_wreq) begin
          we_d    = 1'b1;
          addr_d  = up_waddr;
          wdata_d = up_wdata;
          cyc_d   = 1'b1;
          sel_d   = '1;
          cnt_d   = '0;
          state_d = StBus;
        end else if (up_rreq) begin
          we_d    = 1'b0;
          addr_d  = up_raddr;
          wdata_d = '0;
          cyc_d   = 1'b1;
          sel_d   = '1;
          cnt_d   = '0;
          state_d = StBus;
        end
      end
      StBus: begin
        if (m_wb_ack || m_wb_err || timeout) begin
          cyc_d   = 1'b0;
          sel_d   = '0;
          wdata_d = '0;
          // err dominates a simultaneous ack; no ack at all means timeout
          err_d   = m_wb_err || !m_wb_ack;
          if (!we_q) rdata_d = err_d ? '0 : m_wb_data_i;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cyc_q   <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cyc_q   <= cyc_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_wb_cyc    = cyc_q;
  assign m_wb_stb    = cyc_q;
  assign m_wb_we     = we_q;
  assign m_wb_addr   = {addr_q, {AddrLsb{1'b0}}};
  assign m_wb_data_o = wdata_q;
  assign m_wb_sel    = sel_q;
  assign m_wb_cti    = 3'b000;
  assign m_wb_bte    = 2'b00;
  assign up_rdata    = rdata_q;
  assign up_wack     = (state_q == StResp) && we_q;
  assign up_rack     = (state_q == StResp) && !we_q;
  assign wb_error    = (state_q == StResp) && err_q;

endmodule

// File: tb/tb_up_wishbone_master.sv
// Scoreboard bench for up_wishbone_master: expected bus beats and uP responses are queued
// at issue time and checked by an independent slave model and response monitor.
module tb_up_wishbone_master;

  localparam int unsigned Aw = 16;
  localparam int unsigned Bw = 4;
  localparam int unsigned Dw = 32;
  localparam int unsigned Ww = 14;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          up_rreq = 1'b0, up_wreq = 1'b0;
  logic          up_rack, up_wack;
  logic [Ww-1:0] up_raddr = '0, up_waddr = '0;
  logic [Dw-1:0] up_rdata, up_wdata = '0;
  logic          m_wb_cyc, m_wb_stb, m_wb_we;
  logic [Aw-1:0] m_wb_addr;
  logic [Dw-1:0] m_wb_data_o;
  logic [Bw-1:0] m_wb_sel;
  logic [2:0]    m_wb_cti;
  logic [1:0]    m_wb_bte;
  logic          m_wb_ack = 1'b0, m_wb_err = 1'b0;
  logic [Dw-1:0] m_wb_data_i = '0;
  logic          wb_error;

  up_wishbone_master #(
    .ADDRESS_WIDTH (Aw),
    .BUS_WIDTH     (Bw),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .up_rreq    (up_rreq),
    .up_rack    (up_rack),
    .up_raddr   (up_raddr),
    .up_rdata   (up_rdata),
    .up_wreq    (up_wreq),
    .up_wack    (up_wack),
    .up_waddr   (up_waddr),
    .up_wdata   (up_wdata),
    .m_wb_cyc   (m_wb_cyc),
    .m_wb_stb   (m_wb_stb),
    .m_wb_we    (m_wb_we),
    .m_wb_addr  (m_wb_addr),
    .m_wb_data_o(m_wb_data_o),
    .m_wb_sel   (m_wb_sel),
    .m_wb_cti   (m_wb_cti),
    .m_wb_bte   (m_wb_bte),
    .m_wb_ack   (m_wb_ack),
    .m_wb_err   (m_wb_err),
    .m_wb_data_i(m_wb_data_i),
    .wb_error   (wb_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_write;
    logic [Dw-1:0] rdata;
    bit            err;
  } resp_t;

  typedef struct {
    bit            we;
    logic [Aw-1:0] addr;
    logic [Dw-1:0] data;
    int            len;  // expected cyc-high cycles, 0 = not checked
  } beat_t;

  resp_t resp_q[$];
  beat_t beat_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // slave behaviour: 0 = ack, 1 = err, 2 = never respond
  int            s_mode = 0;
  int            s_wait = 0;
  logic [Dw-1:0] s_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model: checks each beat on cycle start and its cyc length on cycle end.
  beat_t cur;
  bit    active = 1'b0;
  int    cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      m_wb_ack = 1'b0;
      m_wb_err = 1'b0;
      active   = 1'b0;
      cnt      = 0;
    end else if (m_wb_cyc && m_wb_stb) begin
      if (!active) begin
        active = 1'b1;
        cnt    = 0;
        if (beat_q.size() == 0) begin
          check("unexpected_cycle", 64'(m_wb_addr), 64'hFFFF_FFFF);
          cur = '{we: 1'b0, addr: '0, data: '0, len: 0};
        end else begin
          cur = beat_q.pop_front();
          check("wb_we", 64'(m_wb_we), 64'(cur.we));
          check("wb_addr", 64'(m_wb_addr), 64'(cur.addr));
          check("wb_data_o", 64'(m_wb_data_o), 64'(cur.data));
          check("wb_sel", 64'(m_wb_sel), 64'hF);
          check("wb_cti_bte", 64'({m_wb_cti, m_wb_bte}), 64'h0);
        end
      end
      m_wb_ack    = (s_mode == 0) && (cnt == s_wait);
      m_wb_err    = (s_mode == 1) && (cnt == s_wait);
      m_wb_data_i = (cnt == s_wait) ? s_data : 32'hDEAD_0000;
      cnt++;
    end else begin
      m_wb_ack = 1'b0;
      m_wb_err = 1'b0;
      if (active) begin
        if (cur.len != 0) check("cyc_len", 64'(cnt), 64'(cur.len));
        active = 1'b0;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rstn) begin
      if (up_wack && up_rack) check("both_acks", 64'h1, 64'h0);
      if (up_wack || up_rack) begin
        if (resp_q.size() == 0) begin
          check("unexpected_ack", {62'h0, up_wack, up_rack}, 64'h0);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          check("ack_kind_is_write", 64'(up_wack), 64'(r.is_write));
          check("wb_error", 64'(wb_error), 64'(r.err));
          if (!r.is_write) check("up_rdata", 64'(up_rdata), 64'(r.rdata));
        end
      end else if (wb_error) begin
        check("wb_error_without_ack", 64'h1, 64'h0);
      end
    end
  end

  // Holds requests until acked; each is dropped on the edge after its ack is seen.
  task automatic run_req(input bit do_w, input bit do_r);
    bit w_pend, r_pend, got_w, got_r;
    int n;
    w_pend = do_w;
    r_pend = do_r;
    up_wreq = do_w;
    up_rreq = do_r;
    n = 0;
    while ((w_pend || r_pend) && n < 100) begin
      @(negedge clk);
      got_w = w_pend && up_wack;
      got_r = r_pend && up_rack;
      @(posedge clk);
      #1;
      if (got_w) begin up_wreq = 1'b0; w_pend = 1'b0; end
      if (got_r) begin up_rreq = 1'b0; r_pend = 1'b0; end
      n++;
    end
    if (w_pend || r_pend) begin
      check("req_timeout", {62'h0, w_pend, r_pend}, 64'h0);
      up_wreq = 1'b0;
      up_rreq = 1'b0;
    end
  endtask

  task automatic do_write(input logic [Ww-1:0] a, input logic [Dw-1:0] d, input int len,
                          input bit err);
    up_waddr = a;
    up_wdata = d;
    beat_q.push_back('{we: 1'b1, addr: {a, 2'b00}, data: d, len: len});
    resp_q.push_back('{is_write: 1'b1, rdata: '0, err: err});
    run_req(1'b1, 1'b0);
  endtask

  task automatic do_read(input logic [Ww-1:0] a, input logic [Dw-1:0] exp, input int len,
                         input bit err);
    up_raddr = a;
    beat_q.push_back('{we: 1'b0, addr: {a, 2'b00}, data: '0, len: len});
    resp_q.push_back('{is_write: 1'b0, rdata: exp, err: err});
    run_req(1'b0, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_cyc_stb", {62'h0, m_wb_cyc, m_wb_stb}, 64'h0);
    check("rst_acks", {61'h0, up_wack, up_rack, wb_error}, 64'h0);
    check("rst_rdata", 64'(up_rdata), 64'h0);
    check("rst_bus", {m_wb_we, m_wb_addr, m_wb_sel, m_wb_data_o}, 64'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 1: write, ack in first bus cycle
    s_mode = 0; s_wait = 0;
    do_write(14'h3, 32'hAAAA_0001, 1, 1'b0);

    // 2: read with three wait cycles
    s_wait = 3; s_data = 32'hFEED_BABE;
    do_read(14'h2, 32'hFEED_BABE, 4, 1'b0);

    // 3: simultaneous requests, write served first
    s_wait = 1; s_data = 32'h0BAD_F00D;
    up_waddr = 14'h5; up_wdata = 32'h1234_5678; up_raddr = 14'h6;
    beat_q.push_back('{we: 1'b1, addr: 16'h0014, data: 32'h1234_5678, len: 2});
    beat_q.push_back('{we: 1'b0, addr: 16'h0018, data: 32'h0, len: 2});
    resp_q.push_back('{is_write: 1'b1, rdata: '0, err: 1'b0});
    resp_q.push_back('{is_write: 1'b0, rdata: 32'h0BAD_F00D, err: 1'b0});
    run_req(1'b1, 1'b1);

    // 5: slave error on a write; read data must be left alone
    s_mode = 1; s_wait = 2;
    do_write(14'h9, 32'h55AA_55AA, 3, 1'b1);
    check("rdata_hold", 64'(up_rdata), 64'h0BAD_F00D);

    // 4: unanswered read times out after 8 bus cycles
    s_mode = 2;
    do_read(14'h7, 32'h0, 8, 1'b1);

    // 6: reset in the middle of a bus cycle
    s_mode = 2;
    up_raddr = 14'h4;
    beat_q.push_back('{we: 1'b0, addr: 16'h0010, data: 32'h0, len: 0});
    up_rreq = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_cyc", 64'(m_wb_cyc), 64'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_cyc_stb", {62'h0, m_wb_cyc, m_wb_stb}, 64'h0);
    check("async_rst_acks", {61'h0, up_wack, up_rack, wb_error}, 64'h0);
    up_rreq = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    s_mode = 0; s_wait = 0; s_data = 32'h1357_9BDF;
    do_read(14'hA, 32'h1357_9BDF, 1, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("resp_q_empty", 64'(resp_q.size()), 64'h0);
    check("beat_q_empty", 64'(beat_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
